// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect, decode handshake.
// The fetch unit drives it through the master modport.
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_data_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_o,
        output pc_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_data_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_o,
        input  pc_o,
        input  valid_o,
        output ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end with a credit-limited response queue.
// Define FETCH_BYPASS_EN to forward a response straight out when the queue is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t        q_mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;

    entry_t        head;
    logic          q_pop;
    logic          q_push;
    logic          byp;
    logic          req;
    logic          valid;
    logic [AW:0]   count_pop;
    logic [AW+1:0] credit;
    logic [31:0]   instr_out;
    logic [31:0]   pc_out;

    always_comb begin
        head   = q_mem[rd_ptr];
        q_pop  = (count != '0) && bus.ready_i && !bus.redirect_i;
`ifdef FETCH_BYPASS_EN
        byp    = inflight && (count == '0) && !bus.redirect_i;
`else
        byp    = 1'b0;
`endif
        // A bypassed word taken by decode never occupies a slot.
        q_push = inflight && !bus.redirect_i
               && !(byp && bus.ready_i);
        count_pop = count - {{AW{1'b0}}, q_pop};
        credit    = {1'b0, count_pop}
                  + {{(AW+1){1'b0}}, inflight};
        req = !rst_i && !bus.redirect_i
            && (credit < {1'b0, FULL});
        valid = !rst_i && ((count != '0) || byp);
    end

    always_comb begin
        instr_out = '0;
        pc_out    = '0;
        if (valid) begin
            if (count != '0) begin
                instr_out = head.instr;
                pc_out    = head.pc;
            end else begin
                instr_out = bus.imem_data_i;
                pc_out    = inflight_pc;
            end
        end
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc;
    assign bus.valid_o     = valid;
    assign bus.instr_o     = instr_out;
    assign bus.pc_o        = pc_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else if (bus.redirect_i) begin
            // Dropping the in-flight flag discards the returning word.
            pc       <= bus.redirect_pc_i & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= req;
            if (req) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
            if (q_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (q_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count
                   + {{AW{1'b0}}, q_push}
                   - {{AW{1'b0}}, q_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && q_push)
            q_mem[wr_ptr] <= '{instr: bus.imem_data_i,
                               pc:    inflight_pc};
    end
endmodule
